booth_r4_mult_hs: RTL



---
 rtl/booth_pkg.sv | 43 ++++
 rtl/booth_r4_encoder.sv | 37 +++
 rtl/booth_r4_mult_hs.sv | 114 +++++++++++
 3 files changed

// File: rtl/booth_pkg.sv
// rtl/booth_pkg.sv - shared types, Booth code constants and helpers for the radix-4 multiplier
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    typedef enum logic [2:0] {
        ZERO,
        P1,
        P2,
        M1,
        M2
    } digit_sel_t;

    localparam logic [2:0] CODE_000 = 3'b000;
    localparam logic [2:0] CODE_001 = 3'b001;
    localparam logic [2:0] CODE_010 = 3'b010;
    localparam logic [2:0] CODE_011 = 3'b011;
    localparam logic [2:0] CODE_100 = 3'b100;
    localparam logic [2:0] CODE_101 = 3'b101;
    localparam logic [2:0] CODE_110 = 3'b110;
    localparam logic [2:0] CODE_111 = 3'b111;

    function automatic int booth_iter(input int n);
        return (n + 2) / 2;
    endfunction

    function automatic digit_sel_t booth_decode(input logic [2:0] code);
        digit_sel_t sel;
        case (code)
            CODE_001, CODE_010: sel = P1;
            CODE_011:           sel = P2;
            CODE_100:           sel = M2;
            CODE_101, CODE_110: sel = M1;
            default:            sel = ZERO;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/booth_r4_encoder.sv
// rtl/booth_r4_encoder.sv - radix-4 Booth digit to partial term (one's complement + carry for negatives)
module booth_r4_encoder
    import booth_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [2:0]   code,
    input  logic [N:0]   a_ext,
    output logic [N+2:0] term,
    output logic         carry_in
);

    logic [N+2:0] a_x1;
    logic [N+2:0] a_x2;

    assign a_x1 = {{2{a_ext[N]}}, a_ext};
    assign a_x2 = {a_ext[N], a_ext, 1'b0};

    always_comb begin
        term     = '0;
        carry_in = 1'b0;
        case (booth_decode(code))
            P1: term = a_x1;
            P2: term = a_x2;
            M1: begin
                term     = ~a_x1;
                carry_in = 1'b1;
            end
            M2: begin
                term     = ~a_x2;
                carry_in = 1'b1;
            end
            default: term = '0;
        endcase
    end

endmodule

// File: rtl/booth_r4_mult_hs.sv
// rtl/booth_r4_mult_hs.sv - sequential radix-4 Booth multiplier with valid/ready handshakes
module booth_r4_mult_hs
    import booth_pkg::*;
#(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           in_signed,
    input  logic [N-1:0]   multiplicand,
    input  logic [N-1:0]   multiplier,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] product,
    output logic           busy
);

    localparam int ITER = booth_iter(N);
    localparam int BW   = 2 * ITER;
    localparam int CW   = $clog2(ITER + 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic [N:0]    a_reg;
    logic [N+2:0]  acc_hi;
    logic [BW-1:0] b_reg;
    logic          b_prev;

    logic [N:0]     a_ext;
    logic [BW-1:0]  b_pad;
    logic           ext_b;
    logic [N+2:0]   term;
    logic           carry_in;
    logic [N+2:0]   sum;
    logic [N+2:0]   new_acc;
    logic [BW-1:0]  new_b;
    logic [2*N-1:0] product_next;
    logic           accept;

    // Mode only affects the extension bits, so it is folded in at capture time.
    assign a_ext = {in_signed & multiplicand[N-1], multiplicand};
    assign ext_b = in_signed & multiplier[N-1];
    assign b_pad = {{(BW-N){ext_b}}, multiplier};

    booth_r4_encoder #(.N(N)) u_encoder (
        .code     ({b_reg[1:0], b_prev}),
        .a_ext    (a_reg),
        .term     (term),
        .carry_in (carry_in)
    );

    assign sum     = acc_hi + term + {{(N+2){1'b0}}, carry_in};
    assign new_acc = {{2{sum[N+2]}}, sum[N+2:2]};
    assign new_b   = {sum[1:0], b_reg[BW-1:2]};

    generate
        if (2 * N > BW) begin : g_prod_wide
            assign product_next = {new_acc[2*N-BW-1:0], new_b};
        end else begin : g_prod_narrow
            assign product_next = new_b[2*N-1:0];
        end
    endgenerate

    assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            a_reg     <= '0;
            acc_hi    <= '0;
            b_reg     <= '0;
            b_prev    <= 1'b0;
            product   <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else if (accept) begin
            state     <= CALC;
            cnt       <= '0;
            a_reg     <= a_ext;
            acc_hi    <= '0;
            b_reg     <= b_pad;
            b_prev    <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b1;
        end else begin
            case (state)
                CALC: begin
                    acc_hi <= new_acc;
                    b_reg  <= new_b;
                    b_prev <= b_reg[1];
                    cnt    <= cnt + 1'b1;
                    if (cnt == CW'(ITER - 1)) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                        product   <= product_next;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
